ex_unit: RTL and testbench
==========================

EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; low clears all state immediately, release synchronous to clk.
REQ-003 aluop_i  in  8 (`AluOpBus)  operation code from the ID/EX register.
REQ-004 alusel_i  in  3 (`AluSelBus)  result class: NOP, LOGIC, SHIFT, ARITH, DIV.
REQ-005 reg1_i, reg2_i  in  32 each  source operands.
REQ-006 wd_i  in  5 (`RegAddrBus)  destination register; wreg_i  in  1  write enable.
REQ-007 flush_i  in  1  pipeline flush; aborts any divide in progress.
REQ-008 wd_o  out  5  destination forwarded to EX/MEM; wreg_o  out  1  write enable; wdata_o  out  32  result.
REQ-009 stallreq_o  out  1  high while a divide occupies the unit; upstream holds ID/EX inputs stable.

Function
REQ-010 Single-cycle ops (LOGIC: AND/OR/XOR/NOR; SHIFT: SLL/SRL/SRA by reg1_i[4:0]; ARITH: ADD/SUB/SLT/SLTU) produce wdata_o combinationally in the same cycle; wd_o/wreg_o pass through; stallreq_o=0.
REQ-011 ADD/SUB are modulo 2^32, no overflow trap; SLT signed compare, SLTU unsigned, result 32'h1 or 32'h0.
REQ-012 NOP class or unknown aluop: wdata_o=0, wreg_o=0.
REQ-013 Divide ops DIV, DIVU (quotient) and REM, REMU (remainder) use FSM states IDLE, BUSY, DONE.
REQ-014 IDLE: divide op present -> latch operands, op, wd, wreg; go BUSY; stallreq_o=1 from this cycle (cycle 0).
REQ-015 BUSY: one restoring-division step per cycle, 32 cycles (cycles 1..32) via 6-bit counter; stallreq_o=1; wreg_o=0.
REQ-016 DONE (cycle 33): wdata_o=selected result, wd_o/wreg_o from latched values, stallreq_o=0; next state IDLE.
REQ-017 Signed ops: divide magnitudes, quotient negative iff signs differ, remainder takes dividend sign.
REQ-018 Divisor zero: skip BUSY, IDLE->DONE in one cycle; quotient 32'hFFFF_FFFF, remainder = dividend.
REQ-019 Signed overflow (32'h8000_0000 / -1): quotient 32'h8000_0000, remainder 0, full 32-cycle latency.
REQ-020 A divide op seen in DONE is not restarted; upstream advances ID/EX the DONE cycle, so new op is taken in IDLE.
REQ-021 flush_i=1 in any state: next state IDLE, stallreq_o=0 that cycle, wreg_o=0 that cycle; no result issued.
REQ-022 flush_i has priority over a divide start in the same cycle.

Reset
REQ-023 While rst=0: state=IDLE, counter=0, latched operands/dividend/divisor=0, stallreq_o=0, wreg_o=0, wd_o=0, wdata_o=0.
REQ-024 rst asserted mid-divide discards it; after release unit accepts a new op the first clk edge.

Structure
REQ-025 Shared package ex_pkg holds: state enum (IDLE, BUSY, DONE), aluop/alusel constants, DIV_CYCLES=32.
REQ-026 Divider datapath and FSM in sub-module ex_div (start, signed, op, dividend, divisor, flush -> busy, done, quotient, remainder); ex_unit holds single-cycle ALU and output mux.

Verification
REQ-027 ADD 32'h7FFF_FFFF+1, wd=3, wreg=1 -> same cycle wdata_o=32'h8000_0000, wd_o=3, wreg_o=1, stallreq_o=0.
REQ-028 DIV -7 / 2 -> stallreq_o high cycles 0..32, cycle 33 wdata_o=-3 (32'hFFFF_FFFD); REM gives -1.
REQ-029 DIVU 100 / 0 -> DONE at cycle 1, wdata_o=32'hFFFF_FFFF; REMU 100/0 -> 100.
REQ-030 DIV 32'h8000_0000 / 32'hFFFF_FFFF -> cycle 33 wdata_o=32'h8000_0000.
REQ-031 DIVU started, flush_i=1 at cycle 10 -> cycle 10 stallreq_o=0, wreg_o=0; never a result write; next op accepted cycle 11.
REQ-032 rst low at cycle 5 of divide -> all outputs 0 immediately (asynchronous); SRL 32'hF0 by 4 after release -> 32'h0F.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: divider states, opcode and
// result-class encodings, and small operand helpers.
package ex_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_CYCLES = 32;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b011;
  localparam logic [2:0] SEL_DIV   = 3'b100;

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_SUB  = 8'h22;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_REM  = 8'h1C;
  localparam logic [7:0] OP_REMU = 8'h1D;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Magnitude of an operand; unsigned operands pass through untouched.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider with its own sequencing FSM.
//   state | meaning
//   IDLE  | waiting; a start latches operands (or jumps to DONE on zero divisor)
//   BUSY  | one quotient bit per cycle, down-counter from DIV_CYCLES-1 to 0
//   DONE  | quotient/remainder valid for one cycle, then back to IDLE
module ex_div
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic        rem_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        accept,
  output logic        rem_op_q,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] dividend_q;
  logic [31:0] divisor_q;
  logic [31:0] dvd_q;
  logic [31:0] rem_q;
  logic        neg_quo_q, neg_rem_q, zero_q;
  logic [32:0] trial, diff;
  logic        step_bit;
  logic [31:0] step_rem;

  // Next-state logic; flush overrides everything, including a fresh start.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          accept  = 1'b1;
          state_d = (divisor == 32'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 6'd0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    trial    = {rem_q, dvd_q[31]};
    diff     = trial - {1'b0, divisor_q};
    step_bit = ~diff[32];
    step_rem = step_bit ? diff[31:0] : trial[31:0];
  end

  // Operand capture on accept, iteration while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 6'd0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      dvd_q      <= 32'd0;
      rem_q      <= 32'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      rem_op_q   <= 1'b0;
    end else if (accept) begin
      cnt_q      <= 6'(DIV_CYCLES - 1);
      dividend_q <= dividend;
      divisor_q  <= abs32(divisor, is_signed);
      dvd_q      <= abs32(dividend, is_signed);
      rem_q      <= 32'd0;
      neg_quo_q  <= is_signed & (dividend[31] ^ divisor[31]);
      neg_rem_q  <= is_signed & dividend[31];
      zero_q     <= (divisor == 32'd0);
      rem_op_q   <= rem_op;
    end else if (state_q == BUSY && !flush) begin
      rem_q <= step_rem;
      dvd_q <= {dvd_q[30:0], step_bit};
      if (cnt_q != 6'd0) cnt_q <= cnt_q - 6'd1;
    end
  end

  // Sign fix-up; a zero divisor bypasses the iteration entirely.
  always_comb begin
    busy      = ((state_q == BUSY) && !flush) || accept;
    done      = (state_q == DONE) && !flush;
    quotient  = zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? (~dvd_q + 32'd1) : dvd_q);
    remainder = zero_q ? dividend_q    : (neg_rem_q ? (~rem_q + 32'd1) : rem_q);
  end

endmodule

// File: rtl/ex_unit.sv
// Execute stage: single-cycle ALU, multi-cycle divider and the result mux
// feeding the EX/MEM register.
module ex_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  logic        div_req, div_signed, div_rem;
  logic        div_busy, div_done, div_accept, div_rem_q;
  logic [31:0] div_quo, div_remainder;
  logic [4:0]  wd_q;
  logic        wreg_q;
  logic [31:0] alu_res;
  logic        alu_ok;
  logic [4:0]  sh;

  assign div_req    = (alusel_i == SEL_DIV) && is_div_op(aluop_i);
  assign div_signed = (aluop_i == OP_DIV) || (aluop_i == OP_REM);
  assign div_rem    = (aluop_i == OP_REM) || (aluop_i == OP_REMU);
  assign sh         = reg1_i[4:0];

  ex_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_req),
    .is_signed (div_signed),
    .rem_op    (div_rem),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .flush     (flush_i),
    .busy      (div_busy),
    .done      (div_done),
    .accept    (div_accept),
    .rem_op_q  (div_rem_q),
    .quotient  (div_quo),
    .remainder (div_remainder)
  );

  // Destination of the divide in flight, held until its DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q   <= 5'd0;
      wreg_q <= 1'b0;
    end else if (div_accept) begin
      wd_q   <= wd_i;
      wreg_q <= wreg_i;
    end
  end

  // Single-cycle operations; anything unrecognised leaves alu_ok low.
  always_comb begin
    alu_res = 32'd0;
    alu_ok  = 1'b0;
    case (alusel_i)
      SEL_LOGIC: begin
        alu_ok = 1'b1;
        case (aluop_i)
          OP_AND:  alu_res = reg1_i & reg2_i;
          OP_OR:   alu_res = reg1_i | reg2_i;
          OP_XOR:  alu_res = reg1_i ^ reg2_i;
          OP_NOR:  alu_res = ~(reg1_i | reg2_i);
          default: alu_ok  = 1'b0;
        endcase
      end
      SEL_SHIFT: begin
        alu_ok = 1'b1;
        case (aluop_i)
          OP_SLL:  alu_res = reg2_i << sh;
          OP_SRL:  alu_res = reg2_i >> sh;
          OP_SRA:  alu_res = $signed(reg2_i) >>> sh;
          default: alu_ok  = 1'b0;
        endcase
      end
      SEL_ARITH: begin
        alu_ok = 1'b1;
        case (aluop_i)
          OP_ADD:  alu_res = reg1_i + reg2_i;
          OP_SUB:  alu_res = reg1_i - reg2_i;
          OP_SLT:  alu_res = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
          OP_SLTU: alu_res = {31'd0, (reg1_i < reg2_i)};
          default: alu_ok  = 1'b0;
        endcase
      end
      default: alu_ok = 1'b0;
    endcase
  end

  // Result mux; flush kills the write and reset forces every output low.
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    stallreq_o = div_busy;
    if (div_done) begin
      wd_o    = wd_q;
      wreg_o  = wreg_q;
      wdata_o = div_rem_q ? div_remainder : div_quo;
    end else if (!div_req && alu_ok) begin
      wreg_o  = wreg_i;
      wdata_o = alu_res;
    end
    if (flush_i) wreg_o = 1'b0;
    if (!rst) begin
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = 32'd0;
      stallreq_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_unit.sv
// Bench for ex_unit: directed vectors with literal expectations plus a
// cycle-level reference model compared on every falling edge.
module tb_ex_unit;
  import ex_pkg::*;

  logic        clk, rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg, flush;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_cmp = 0;

  ex_unit dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .flush_i    (flush),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic alu_ref(input logic [2:0] sel, input logic [7:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r);
    r = 32'd0;
    if (sel == SEL_LOGIC && op == OP_AND)  begin r = a & b; return 1'b1; end
    if (sel == SEL_LOGIC && op == OP_OR)   begin r = a | b; return 1'b1; end
    if (sel == SEL_LOGIC && op == OP_XOR)  begin r = a ^ b; return 1'b1; end
    if (sel == SEL_LOGIC && op == OP_NOR)  begin r = ~(a | b); return 1'b1; end
    if (sel == SEL_SHIFT && op == OP_SLL)  begin r = b << a[4:0]; return 1'b1; end
    if (sel == SEL_SHIFT && op == OP_SRL)  begin r = b >> a[4:0]; return 1'b1; end
    if (sel == SEL_SHIFT && op == OP_SRA)  begin r = $signed(b) >>> a[4:0]; return 1'b1; end
    if (sel == SEL_ARITH && op == OP_ADD)  begin r = a + b; return 1'b1; end
    if (sel == SEL_ARITH && op == OP_SUB)  begin r = a - b; return 1'b1; end
    if (sel == SEL_ARITH && op == OP_SLT)  begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; return 1'b1; end
    if (sel == SEL_ARITH && op == OP_SLTU) begin r = (a < b) ? 32'd1 : 32'd0; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [31:0] div_ref(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic sgn, rem;
    sgn = (op == OP_DIV) || (op == OP_REM);
    rem = (op == OP_REM) || (op == OP_REMU);
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction

  function automatic logic div_in(input logic [2:0] sel, input logic [7:0] op);
    return sel == SEL_DIV && (op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU);
  endfunction

  bit          m_pend;
  int          m_left;
  logic [31:0] m_res;
  logic [4:0]  m_wd;
  logic        m_wreg;

  // Pending divide: cycles left until its result, result, destination.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend <= 0;
      m_left <= 0;
    end else if (flush) begin
      m_pend <= 0;
    end else if (m_pend) begin
      if (m_left == 0) m_pend <= 0;
      else             m_left <= m_left - 1;
    end else if (div_in(alusel, aluop)) begin
      m_pend <= 1;
      m_left <= (reg2 == 32'd0) ? 0 : DIV_CYCLES;
      m_res  <= div_ref(aluop, reg1, reg2);
      m_wd   <= wd;
      m_wreg <= wreg;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      logic        e_stall, e_wreg, c_data, c_wd, ok;
      logic [4:0]  e_wd;
      logic [31:0] e_data, r;
      e_stall = 0; e_wreg = 0; e_wd = 0; e_data = 0; c_data = 1; c_wd = 1;
      if (!rst) begin
        e_wd = 0;
      end else if (m_pend && m_left == 0) begin
        e_wd = m_wd; e_wreg = m_wreg & ~flush; e_data = m_res;
        c_data = ~flush; c_wd = ~flush;
      end else if (m_pend || div_in(alusel, aluop)) begin
        e_stall = ~flush; c_data = 0; c_wd = 0;
      end else begin
        ok = alu_ref(alusel, aluop, reg1, reg2, r);
        e_wd = wd;
        e_wreg = ok & wreg & ~flush;
        e_data = ok ? r : 32'd0;
      end
      chk("m_stall", 32'(stallreq_o), 32'(e_stall));
      chk("m_wreg", 32'(wreg_o), 32'(e_wreg));
      if (c_wd)   chk("m_wd", 32'(wd_o), 32'(e_wd));
      if (c_data) chk("m_wdata", wdata_o, e_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [2:0] s, input logic [7:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w);
    alusel = s; aluop = o; reg1 = a; reg2 = b; wd = d; wreg = w;
  endtask

  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    next_cycle();
    apply(SEL_DIV, op, a, b, 5'd7, 1'b1);
    cyc = 0;
    @(negedge clk);
    while (stallreq_o === 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_lat"}, 32'(cyc), 32'(lat));
    chk({name, "_data"}, wdata_o, exp);
    chk({name, "_wreg"}, 32'(wreg_o), 32'd1);
    chk({name, "_wd"}, 32'(wd_o), 32'd7);
    next_cycle();
    apply(SEL_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] a, b, exp;
    logic        wr;
  } vec_t;

  vec_t vecs[14];
  int   wr_seen;

  initial begin
    rst = 1'b0; flush = 1'b0;
    apply(SEL_ARITH, OP_ADD, 32'd1, 32'd2, 5'd9, 1'b1);
    #2;
    run_cmp = 1;
    @(negedge clk);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    next_cycle();
    rst = 1'b1;

    vecs[0]  = '{SEL_ARITH, OP_ADD,  32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 1'b1};
    vecs[1]  = '{SEL_ARITH, OP_SUB,  32'd5,         32'd7,        32'hFFFF_FFFE, 1'b1};
    vecs[2]  = '{SEL_LOGIC, OP_AND,  32'hF0F0,      32'hFF00,     32'hF000,      1'b1};
    vecs[3]  = '{SEL_LOGIC, OP_OR,   32'hF0F0,      32'h0F0F,     32'hFFFF,      1'b1};
    vecs[4]  = '{SEL_LOGIC, OP_XOR,  32'hFFFF,      32'h0F0F,     32'hF0F0,      1'b1};
    vecs[5]  = '{SEL_LOGIC, OP_NOR,  32'd0,         32'd0,        32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{SEL_SHIFT, OP_SLL,  32'h24,        32'h1,        32'h10,        1'b1};
    vecs[7]  = '{SEL_SHIFT, OP_SRL,  32'd4,         32'hF0,       32'h0F,        1'b1};
    vecs[8]  = '{SEL_SHIFT, OP_SRA,  32'd4,         32'h8000_0000, 32'hF800_0000, 1'b1};
    vecs[9]  = '{SEL_ARITH, OP_SLT,  32'hFFFF_FFFF, 32'd1,        32'd1,         1'b1};
    vecs[10] = '{SEL_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'd1,        32'd0,         1'b1};
    vecs[11] = '{SEL_NOP,   OP_ADD,  32'd1,         32'd1,        32'd0,         1'b0};
    vecs[12] = '{SEL_LOGIC, 8'hFF,   32'd1,         32'd1,        32'd0,         1'b0};
    vecs[13] = '{SEL_ARITH, OP_ADD,  32'hFFFF_FFFF, 32'd2,        32'd1,         1'b1};

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3), 1'b1);
      @(negedge clk);
      chk($sformatf("alu%0d_data", i), wdata_o, vecs[i].exp);
      chk($sformatf("alu%0d_wreg", i), 32'(wreg_o), 32'(vecs[i].wr));
      chk($sformatf("alu%0d_stall", i), 32'(stallreq_o), 32'd0);
      if (vecs[i].wr) chk($sformatf("alu%0d_wd", i), 32'(wd_o), 32'(i + 3));
      next_cycle();
    end
    apply(SEL_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);

    run_div("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_div("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_div("divu_100_0", OP_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run_div("remu_100_0", OP_REMU, 32'd100,       32'd0,         32'd100,       1);
    run_div("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_div("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);
    run_div("div_7_m2",   OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_div("rem_7_m2",   OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33);
    run_div("divu_big",   OP_DIVU, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 33);
    run_div("remu_big",   OP_REMU, 32'hFFFF_FFFF, 32'd16,        32'hF,         33);
    run_div("rem_m5_0",   OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);

    // Flush at cycle 10 of a DIVU.
    next_cycle();
    apply(SEL_DIV, OP_DIVU, 32'd1000, 32'd7, 5'd9, 1'b1);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(stallreq_o), 32'd0);
    chk("flush_wreg", 32'(wreg_o), 32'd0);
    next_cycle();
    flush = 1'b0;
    apply(SEL_ARITH, OP_ADD, 32'd2, 32'd3, 5'd4, 1'b1);
    @(negedge clk);
    chk("post_flush_data", wdata_o, 32'd5);
    chk("post_flush_wreg", 32'(wreg_o), 32'd1);
    chk("post_flush_stall", 32'(stallreq_o), 32'd0);
    next_cycle();
    apply(SEL_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
    wr_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wreg_o === 1'b1) wr_seen++;
    end
    chk("flush_no_result", 32'(wr_seen), 32'd0);

    // Reset asserted at cycle 5 of a divide.
    next_cycle();
    apply(SEL_DIV, OP_DIV, 32'd1000, 32'd3, 5'd12, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_stall", 32'(stallreq_o), 32'd0);
    chk("arst_wreg", 32'(wreg_o), 32'd0);
    chk("arst_wd", 32'(wd_o), 32'd0);
    chk("arst_wdata", wdata_o, 32'd0);
    next_cycle();
    rst = 1'b1;
    apply(SEL_SHIFT, OP_SRL, 32'd4, 32'hF0, 5'd2, 1'b1);
    @(negedge clk);
    chk("post_rst_srl", wdata_o, 32'h0F);
    chk("post_rst_wreg", 32'(wreg_o), 32'd1);
    next_cycle();
    apply(SEL_DIV, OP_DIVU, 32'd40, 32'd0, 5'd6, 1'b1);
    @(negedge clk);
    chk("post_rst_accept", 32'(stallreq_o), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("post_rst_div_data", wdata_o, 32'hFFFF_FFFF);
    next_cycle();
    apply(SEL_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (3) next_cycle();

    run_cmp = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: got running want finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
